key_debounce_bank: RTL and testbench

KEY_DEBOUNCE_BANK -- requirements
Module: key_debounce_bank

---
 rtl/key_pkg.sv | 21 ++
 rtl/key_debounce_ch.sv | 140 ++++++++++++++
 rtl/key_debounce_bank.sv | 45 ++++
 tb/tb_key_debounce_bank.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and default timing for the key debounce bank.
//   key_state_e   : per-channel hold-tracking state
//   DEF_*         : default timing in clock cycles (12 MHz clock)
//   key_max       : larger of two limits, used to size shared counters
package key_pkg;

  typedef enum logic [1:0] {
    KS_RELEASED = 2'd0,
    KS_HELD     = 2'd1,
    KS_LONG     = 2'd2
  } key_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 12000;     // 1 ms
  localparam int unsigned DEF_LONG_CYCLES     = 12000000;  // 1 s
  localparam int unsigned DEF_REPEAT_CYCLES   = 2400000;   // 200 ms

  function automatic int unsigned key_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, polarity normalisation, debounce
// counter and press/long/repeat tracking FSM.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_key        : raw asynchronous pin
//   o_level      : debounced level, 1 = pressed
//   o_press, o_release, o_long, o_repeat : one-cycle event pulses
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(key_max(LONG_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic        RelRaw = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic             sync1_q, sync2_q;
  logic             key_pressed;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;
  logic             level_q, level_d;
  logic             toggle;
  logic             press_ev, release_ev;
  logic [HoldW-1:0] hold_q, hold_d;
  key_state_e       state_q, state_d;
  logic             press_q, release_q, long_q, repeat_q;
  logic             long_d, repeat_d;

  assign key_pressed = ACTIVE_LOW ? ~sync2_q : sync2_q;

  // Debounce: the level flips on the cycle the counter would reach its limit.
  always_comb begin
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    toggle   = 1'b0;
    if (key_pressed == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt_d = '0;
      level_d  = ~level_q;
      toggle   = 1'b1;
    end else begin
      db_cnt_d = db_cnt_q + DbW'(1);
    end
  end

  assign press_ev   = toggle & ~level_q;
  assign release_ev = toggle &  level_q;

  // Hold counter is shared between the long-press wait and the repeat period.
  // Release is checked first so it suppresses a coincident long/repeat pulse.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    unique case (state_q)
      KS_RELEASED: begin
        if (press_ev) begin
          state_d = KS_HELD;
          hold_d  = '0;
        end
      end
      KS_HELD: begin
        if (release_ev) begin
          state_d = KS_RELEASED;
          hold_d  = '0;
        end else if (hold_q == HoldW'(LONG_CYCLES - 1)) begin
          state_d = KS_LONG;
          hold_d  = '0;
          long_d  = 1'b1;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      KS_LONG: begin
        if (release_ev) begin
          state_d = KS_RELEASED;
          hold_d  = '0;
        end else if (REPEAT_EN) begin
          if (hold_q == HoldW'(REPEAT_CYCLES - 1)) begin
            hold_d   = '0;
            repeat_d = 1'b1;
          end else begin
            hold_d = hold_q + HoldW'(1);
          end
        end
      end
      default: begin
        state_d = KS_RELEASED;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q   <= RelRaw;
      sync2_q   <= RelRaw;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      hold_q    <= '0;
      state_q   <= KS_RELEASED;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= i_key;
      sync2_q   <= sync1_q;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      hold_q    <= hold_d;
      state_q   <= state_d;
      press_q   <= press_ev;
      release_q <= release_ev;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_repeat  = repeat_q;

endmodule

// File: rtl/key_debounce_bank.sv
// Bank of N_KEYS independent debounced key channels.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_key        : raw asynchronous key pins
//   o_level      : debounced levels, 1 = pressed
//   o_press, o_release, o_long, o_repeat : per-key one-cycle event pulses
module key_debounce_bank
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_KEYS-1:0] i_key,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_long,
  output logic [N_KEYS-1:0] o_repeat
);

  for (genvar g = 0; g < int'(N_KEYS); g++) begin : gen_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .REPEAT_EN       (REPEAT_EN)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_key     (i_key[g]),
      .o_level   (o_level[g]),
      .o_press   (o_press[g]),
      .o_release (o_release[g]),
      .o_long    (o_long[g]),
      .o_repeat  (o_repeat[g])
    );
  end

endmodule

// File: tb/tb_key_debounce_bank.sv
module tb_key_debounce_bank;

  localparam int KPress = 0, KRelease = 1, KLong = 2, KRepeat = 3;

  typedef struct {
    int cyc;
    int dut;
    int kind;
    int ch;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key, key_nr;
  logic [3:0] level, press, release_p, long_p, repeat_p;
  logic [3:0] level_nr, press_nr, release_nr, long_nr, repeat_nr;

  int  cyc = 0;
  int  n_assert = 0;
  int  n_fail = 0;
  bit  chk_en = 1'b0;
  ev_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_debounce_bank #(
    .N_KEYS(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(5),
    .ACTIVE_LOW(1'b1), .REPEAT_EN(1'b1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_key(key), .o_level(level), .o_press(press),
    .o_release(release_p), .o_long(long_p), .o_repeat(repeat_p)
  );

  key_debounce_bank #(
    .N_KEYS(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(5),
    .ACTIVE_LOW(1'b1), .REPEAT_EN(1'b0)
  ) dut_nr (
    .i_clk(clk), .i_rst(rst), .i_key(key_nr), .o_level(level_nr), .o_press(press_nr),
    .o_release(release_nr), .o_long(long_nr), .o_repeat(repeat_nr)
  );

  function automatic void push(input int c, input int d, input int k, input int ch);
    ev_t e;
    e.cyc = c; e.dut = d; e.kind = k; e.ch = ch;
    exp_q.push_back(e);
  endfunction

  // Every cycle the full pulse vectors of both DUTs are compared against the
  // events scheduled for this cycle; unscheduled pulses show up as mismatches.
  always @(negedge clk) begin
    logic [3:0] exp_v [2][4];
    logic [3:0] obs_v [2][4];
    if (chk_en) begin
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < 4; k++) exp_v[d][k] = 4'b0;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc == cyc) begin
          exp_v[exp_q[i].dut][exp_q[i].kind][exp_q[i].ch] = 1'b1;
          exp_q.delete(i);
        end
      end
      obs_v[0][KPress] = press;     obs_v[0][KRelease] = release_p;
      obs_v[0][KLong]  = long_p;    obs_v[0][KRepeat]  = repeat_p;
      obs_v[1][KPress] = press_nr;  obs_v[1][KRelease] = release_nr;
      obs_v[1][KLong]  = long_nr;   obs_v[1][KRepeat]  = repeat_nr;
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 4; k++) begin
          n_assert++;
          assert (obs_v[d][k] === exp_v[d][k]) else begin
            n_fail++;
            $error("FAIL pulse dut%0d kind%0d cyc%0d: observed %b expected %b",
                   d, k, cyc, obs_v[d][k], exp_v[d][k]);
          end
        end
      end
    end
  end

  task automatic chk_level(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int c, p, p4;
    rst    = 1'b1;
    key    = 4'hF;
    key_nr = 4'hF;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk_level("reset_level", level, 4'b0000);
    chk_level("reset_level_nr", level_nr, 4'b0000);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Key 0 press; release lands exactly when long would fire.
    c = cyc; key[0] = 1'b0; p = c + 6;
    push(p, 0, KPress, 0);
    wait_until(p + 1);
    chk_level("level0_pressed", level, 4'b0001);
    wait_until(p + 14);
    key[0] = 1'b1;
    push(p + 20, 0, KRelease, 0);
    wait_until(p + 22);
    chk_level("level0_released", level, 4'b0000);

    // Key 1 short glitch: 3 cycles low must be ignored.
    c = cyc; key[1] = 1'b0;
    wait_until(c + 3);
    key[1] = 1'b1;
    wait_until(c + 12);
    chk_level("glitch_level1", level, 4'b0000);

    // Key 2 long press with repeats; key 3 short press overlapping it.
    c = cyc; key[2] = 1'b0; p = c + 6;
    push(p, 0, KPress, 2);
    push(p + 20, 0, KLong, 2);
    for (int r = 25; r <= 40; r += 5) push(p + r, 0, KRepeat, 2);
    wait_until(p + 5);
    key[3] = 1'b0; p4 = p + 11;
    push(p4, 0, KPress, 3);
    wait_until(p4 + 1);
    chk_level("level2_3_held", level, 4'b1100);
    wait_until(p4 + 4);
    key[3] = 1'b1;
    push(p4 + 10, 0, KRelease, 3);
    wait_until(p + 30);
    chk_level("level2_long", level, 4'b0100);
    wait_until(p + 39);
    key[2] = 1'b1;
    push(p + 45, 0, KRelease, 2);  // coincides with a repeat slot; release wins
    wait_until(p + 50);
    chk_level("level2_released", level, 4'b0000);

    // All four pressed, reset pulsed mid-hold, keys held through it.
    c = cyc; key = 4'h0;
    for (int k = 0; k < 4; k++) push(c + 6, 0, KPress, k);
    wait_until(c + 8);
    chk_level("all_held", level, 4'b1111);
    wait_until(c + 10);
    rst = 1'b1;
    wait_until(c + 11);
    chk_level("mid_hold_reset", level, 4'b0000);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) push(c + 17, 0, KPress, k);
    wait_until(c + 17);
    chk_level("after_reset_press", level, 4'b1111);
    key = 4'hF;
    for (int k = 0; k < 4; k++) push(c + 23, 0, KRelease, k);
    wait_until(c + 30);
    chk_level("all_released", level, 4'b0000);

    // Repeat disabled: long once, never a repeat.
    c = cyc; key_nr[0] = 1'b0; p = c + 6;
    push(p, 1, KPress, 0);
    push(p + 20, 1, KLong, 0);
    wait_until(p + 40);
    chk_level("nr_level_held", level_nr, 4'b0001);
    wait_until(p + 60);
    key_nr[0] = 1'b1;
    push(p + 66, 1, KRelease, 0);
    wait_until(p + 75);
    chk_level("nr_level_released", level_nr, 4'b0000);

    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
